cpu_mem_loader: RTL and testbench

Host-side control block for the 5-stage CPU. It writes programs into instruction memory and initial data into data memory, and it reads data memory back. It runs the CPU for a bounded number of cycles by gating the CPU reset. It sits between the host command/register interface and the top-level CPU. It is the writer/driver end of the path that the simulation monitor only observes.

---
 rtl/cpu_mem_loader_pkg.sv | 26 ++
 rtl/cpu_mem_loader_run_counter.sv | 37 +++
 rtl/cpu_mem_loader.sv | 152 +++++++++++++++
 tb/tb_cpu_mem_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_loader_pkg.sv
// Shared constants for the host-side memory loader: widths, command opcodes
// and the loader state encoding.
package cpu_mem_loader_pkg;

  localparam int LDR_IMEM_AW = 9;
  localparam int LDR_DMEM_AW = 8;
  localparam int LDR_IDATA_W = 32;
  localparam int LDR_DDATA_W = 64;
  localparam int LDR_CNT_W   = 16;
  localparam int LDR_CMD_AW  = 9;

  localparam logic [1:0] OP_IWR = 2'b00;
  localparam logic [1:0] OP_DWR = 2'b01;
  localparam logic [1:0] OP_DRD = 2'b10;
  localparam logic [1:0] OP_RUN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RESP,
    ST_RUN
  } ldr_state_e;

endpackage

// File: rtl/cpu_mem_loader_run_counter.sv
// Run-length counter for the loader: counts CPU cycles while enabled and
// flags the cycle in which the count reaches the terminal value.
module loader_run_counter
  import cpu_mem_loader_pkg::*;
#(
  parameter int CNT_W = LDR_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = en_i && (count_q == term_i);

endmodule

// File: rtl/cpu_mem_loader.sv
// Host-side loader: writes instruction/data memory, reads data memory back,
// and runs the CPU for a bounded number of cycles by gating its reset.
module cpu_mem_loader
  import cpu_mem_loader_pkg::*;
#(
  parameter int IMEM_AW = LDR_IMEM_AW,
  parameter int DMEM_AW = LDR_DMEM_AW,
  parameter int IDATA_W = LDR_IDATA_W,
  parameter int DDATA_W = LDR_DDATA_W,
  parameter int CNT_W   = LDR_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [LDR_CMD_AW-1:0] cmd_addr,
  input  logic [DDATA_W-1:0]    cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DDATA_W-1:0]    rsp_data,
  output logic                  cpu_reset,
  output logic                  imem_we,
  output logic [IMEM_AW-1:0]    imem_addr,
  output logic [IDATA_W-1:0]    imem_wdata,
  output logic                  dmem_sel,
  output logic                  dmem_we,
  output logic [DMEM_AW-1:0]    dmem_addr,
  output logic [DDATA_W-1:0]    dmem_wdata,
  input  logic [DDATA_W-1:0]    dmem_rdata
);

  ldr_state_e         state_q, state_d;
  logic               cmd_ready_q;
  logic               cpu_reset_q, dmem_sel_q;
  logic               imem_we_q, dmem_we_q;
  logic [IMEM_AW-1:0] imem_addr_q;
  logic [IDATA_W-1:0] imem_wdata_q;
  logic [DMEM_AW-1:0] dmem_addr_q;
  logic [DDATA_W-1:0] dmem_wdata_q;
  logic [DDATA_W-1:0] rsp_data_q;
  logic [CNT_W-1:0]   run_n_q;
  logic               accept, run_zero, run_last, run_tc;

  assign run_zero = (cmd_wdata[CNT_W-1:0] == '0);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    run_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          accept = 1'b1;
          case (cmd_op)
            OP_IWR, OP_DWR: state_d = ST_WRITE;
            OP_DRD:         state_d = ST_RD_ISSUE;
            default:        state_d = run_zero ? ST_RESP : ST_RUN;
          endcase
        end
      end
      ST_WRITE:    state_d = ST_IDLE;
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT:  state_d = ST_RESP;
      ST_RESP:     if (rsp_ready) state_d = ST_IDLE;
      ST_RUN: begin
        if (run_tc) begin
          run_last = 1'b1;
          state_d  = ST_RESP;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // Write strobes last one cycle; CPU reset and memory ownership flip only on RUN entry/exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      cpu_reset_q  <= 1'b1;
      dmem_sel_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      rsp_data_q   <= '0;
      run_n_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      imem_we_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      if (accept) begin
        case (cmd_op)
          OP_IWR: begin
            imem_addr_q  <= cmd_addr[IMEM_AW-1:0];
            imem_wdata_q <= cmd_wdata[IDATA_W-1:0];
            imem_we_q    <= 1'b1;
          end
          OP_DWR: begin
            dmem_addr_q  <= cmd_addr[DMEM_AW-1:0];
            dmem_wdata_q <= cmd_wdata;
            dmem_we_q    <= 1'b1;
          end
          OP_DRD: dmem_addr_q <= cmd_addr[DMEM_AW-1:0];
          default: begin
            run_n_q <= cmd_wdata[CNT_W-1:0];
            if (run_zero) begin
              rsp_data_q <= '0;
            end else begin
              cpu_reset_q <= 1'b0;
              dmem_sel_q  <= 1'b0;
            end
          end
        endcase
      end
      if (state_q == ST_RD_WAIT) begin
        rsp_data_q <= dmem_rdata;
      end
      if (run_last) begin
        rsp_data_q  <= {{(DDATA_W-CNT_W){1'b0}}, run_n_q};
        cpu_reset_q <= 1'b1;
        dmem_sel_q  <= 1'b1;
      end
    end
  end

  loader_run_counter #(.CNT_W(CNT_W)) u_run_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (accept && (cmd_op == OP_RUN)),
    .en_i   (state_q == ST_RUN),
    .term_i (run_n_q - CNT_W'(1)),
    .tc_o   (run_tc)
  );

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = rsp_data_q;
  assign cpu_reset  = cpu_reset_q;
  assign dmem_sel   = dmem_sel_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Self-checking bench for cpu_mem_loader: vector table plus hand-written
// sequences for write timing, read back-pressure, RUN gating and mid-run reset.
module tb_cpu_mem_loader;
  import cpu_mem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [8:0]  cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        cpu_reset;
  logic        imem_we;
  logic [8:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_sel;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata = '0;

  int total = 0;
  int bad = 0;
  int lowCycles = 0;
  int selDiff = 0;
  int weWhileCpu = 0;
  int imemWeCycles = 0;

  logic [63:0] dmem [0:255];
  logic [31:0] imem [0:511];
  logic [63:0] expQ [$];

  typedef struct {
    logic [1:0]  op;
    logic [8:0]  addr;
    logic [63:0] wdata;
    bit          hasRsp;
    logic [63:0] expRsp;
  } vec_t;
  vec_t vecs [11];

  cpu_mem_loader dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cpu_reset(cpu_reset),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_sel(dmem_sel), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  // Memories with one-cycle synchronous read, written only when the loader owns them.
  always @(posedge clk) begin
    if (dmem_we && dmem_sel) dmem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= dmem[dmem_addr];
    if (imem_we) imem[imem_addr] <= imem_wdata;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (!cpu_reset) lowCycles++;
      if (dmem_sel != cpu_reset) selDiff++;
      if (dmem_we && !dmem_sel) weWhileCpu++;
      if (imem_we) imemWeCycles++;
    end
  end

  task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [8:0] a, input logic [63:0] d);
    int budget = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!cmd_ready) checkVal("cmd_accept_timeout", 64'(budget), 64'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int holdOff, output int latency);
    logic [63:0] expv;
    logic [63:0] held;
    int budget = 0;
    bit stable = 1'b1;
    expv = '0;
    if (expQ.size() > 0) expv = expQ.pop_front();
    else checkVal({name, "_queue_empty"}, 64'd0, 64'd1);
    while (!rsp_valid && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    latency = budget;
    checkVal({name, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    held = rsp_data;
    repeat (holdOff) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== held) stable = 1'b0;
    end
    if (holdOff > 0) checkVal({name, "_stable"}, 64'(stable), 64'd1);
    checkVal({name, "_data"}, held, expv);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkVal({name, "_valid_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    for (int i = 0; i < 512; i++) imem[i] = '0;

    vecs[0]  = '{OP_DWR, 9'h003, 64'hDEADBEEF00000001, 1'b0, 64'h0};
    vecs[1]  = '{OP_DRD, 9'h003, 64'h0, 1'b1, 64'hDEADBEEF00000001};
    vecs[2]  = '{OP_DWR, 9'h1FF, 64'hA5A5A5A55A5A5A5A, 1'b0, 64'h0};
    vecs[3]  = '{OP_DRD, 9'h0FF, 64'h0, 1'b1, 64'hA5A5A5A55A5A5A5A};
    vecs[4]  = '{OP_DWR, 9'h010, 64'h0123456789ABCDEF, 1'b0, 64'h0};
    vecs[5]  = '{OP_DRD, 9'h110, 64'h0, 1'b1, 64'h0123456789ABCDEF};
    vecs[6]  = '{OP_RUN, 9'h000, 64'hFFFF_0000_0000_0005, 1'b1, 64'd5};
    vecs[7]  = '{OP_RUN, 9'h000, 64'hFFFF_FFFF_FFFF_0000, 1'b1, 64'd0};
    vecs[8]  = '{OP_RUN, 9'h000, 64'd1, 1'b1, 64'd1};
    vecs[9]  = '{OP_DRD, 9'h003, 64'h0, 1'b1, 64'hDEADBEEF00000001};
    vecs[10] = '{OP_IWR, 9'h1FF, 64'h0000_0000_CAFE_F00D, 1'b0, 64'h0};

    // Reset values, then first cycle after release.
    #1 reset = 1'b1;
    #2;
    checkVal("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    checkVal("rst_dmem_sel", 64'(dmem_sel), 64'd1);
    checkVal("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkVal("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkVal("rst_rsp_data", rsp_data, 64'd0);
    repeat (2) @(negedge clk);
    checkVal("rst_cmd_ready_held", 64'(cmd_ready), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkVal("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkVal("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);

    // IWR: one write strobe cycle, ready again two cycles after acceptance.
    imemWeCycles = 0;
    applyStimulus(OP_IWR, 9'd5, 64'h0000_0000_1234_5678);
    checkVal("iwr_we", 64'(imem_we), 64'd1);
    checkVal("iwr_addr", 64'(imem_addr), 64'd5);
    checkVal("iwr_wdata", 64'(imem_wdata), 64'h12345678);
    checkVal("iwr_ready_low", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    checkVal("iwr_we_drop", 64'(imem_we), 64'd0);
    checkVal("iwr_ready_back", 64'(cmd_ready), 64'd1);
    checkVal("iwr_we_cycles", 64'(imemWeCycles), 64'd1);
    checkVal("iwr_mem", 64'(imem[5]), 64'h12345678);

    // Table-driven vectors through the scoreboard.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].hasRsp) expQ.push_back(vecs[i].expRsp);
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].hasRsp) checkOutput($sformatf("vec%0d", i), 0, lat);
    end
    repeat (2) @(posedge clk); #1;
    checkVal("iwr_wrap_mem", 64'(imem[511]), 64'hCAFEF00D);

    // DRD latency and back-pressure with rsp_ready held low.
    expQ.push_back(64'hDEADBEEF00000001);
    applyStimulus(OP_DRD, 9'd3, 64'd0);
    checkOutput("drd_hold", 4, lat);
    checkVal("drd_latency", 64'(lat), 64'd2);

    // RUN 20 with a DWR held pending throughout.
    begin
      int readyHits = 0;
      int budget = 0;
      lowCycles = 0;
      selDiff = 0;
      weWhileCpu = 0;
      expQ.push_back(64'd20);
      applyStimulus(OP_RUN, 9'd0, 64'd20);
      checkVal("run_first_cpu_reset", 64'(cpu_reset), 64'd0);
      checkVal("run_first_dmem_sel", 64'(dmem_sel), 64'd0);
      cmd_valid = 1'b1;
      cmd_op    = OP_DWR;
      cmd_addr  = 9'd7;
      cmd_wdata = 64'hFEED_FACE_0BAD_CAFE;
      while (!rsp_valid && budget < 200) begin
        if (cmd_ready) readyHits++;
        @(posedge clk); #1;
        budget++;
      end
      if (cmd_ready) readyHits++;
      checkOutput("run20", 0, lat);
      checkVal("run20_ready_while_busy", 64'(readyHits), 64'd0);
      checkVal("run20_low_cycles", 64'(lowCycles), 64'd20);
      checkVal("run20_sel_tracks", 64'(selDiff), 64'd0);
      applyStimulus(OP_DWR, 9'd7, 64'hFEED_FACE_0BAD_CAFE);
      expQ.push_back(64'hFEED_FACE_0BAD_CAFE);
      applyStimulus(OP_DRD, 9'd7, 64'd0);
      checkOutput("pending_dwr", 0, lat);
      checkVal("no_we_while_cpu", 64'(weWhileCpu), 64'd0);
    end

    // RUN 0: immediate response, CPU never released.
    lowCycles = 0;
    expQ.push_back(64'd0);
    applyStimulus(OP_RUN, 9'd0, 64'd0);
    checkVal("run0_immediate", 64'(rsp_valid), 64'd1);
    checkOutput("run0", 0, lat);
    checkVal("run0_low_cycles", 64'(lowCycles), 64'd0);

    // Reset seven cycles into RUN 100.
    applyStimulus(OP_RUN, 9'd0, 64'd100);
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkVal("midrun_cpu_reset", 64'(cpu_reset), 64'd1);
    checkVal("midrun_dmem_sel", 64'(dmem_sel), 64'd1);
    checkVal("midrun_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    expQ.push_back(64'h0123456789ABCDEF);
    applyStimulus(OP_DRD, 9'h010, 64'd0);
    checkOutput("after_reset_drd", 0, lat);
    checkVal("after_reset_queue_empty", 64'(expQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
